mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters. It owns the mux select lines, issues one-hot grants with bounded hold time, and registers the selected data with a valid flag. It sits directly above the lab's 4:1 mux cell and replaces hand-driven select stimulus with a clocked scheduler.

## Interface
- `DATA_W`, default 1: width of each requester's data word.
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester keeps the grant while others wait; legal range 1–15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: request per requester; bit i = requester i.
- `din`  in  4*DATA_W: packed data; requester i occupies `din[i*DATA_W +: DATA_W]`.
- `gnt`  out  4: registered one-hot grant, or all zero.
- `sel`  out  2: registered mux select, equal to the index of the granted requester.
- `dout`  out  DATA_W: registered mux output.
- `valid`  out  1: high when `dout` holds data captured under a grant.

## Operation
- States:
  - `IDLE`: no grant.
  - `GRANT`: one owner holds `gnt`.
- Round-robin pointer `last`: index of the most recent owner. The search order for a new grant is `last+1`, `last+2`, `last+3`, `last` (mod 4).
- In `IDLE`:
  - If any `req` bit is set, grant the first set bit in search order, load `hold_cnt` = 1, go to `GRANT`.
  - Otherwise stay in `IDLE`.
- In `GRANT` with owner k:
  - `req[k]` low: release. If other requests are pending, grant the next one in search order in the same edge, with no idle bubble. Otherwise go to `IDLE` with `gnt` = 0.
  - `req[k]` high and `hold_cnt` < `MAX_HOLD`: keep owner k and increment `hold_cnt`.
  - `req[k]` high, `hold_cnt` == `MAX_HOLD`, another request pending: switch to the next requester in search order and load `hold_cnt` = 1.
  - `req[k]` high, `hold_cnt` == `MAX_HOLD`, no other request: keep owner k and reload `hold_cnt` = 1. The counter never saturates past `MAX_HOLD`.
- On every grant, `last` takes the new owner's index. `sel` always equals the encoded `gnt`. While in `IDLE`, `sel` holds its previous value.
- Data path, evaluated every edge:
  - `dout` ← `din` slice selected by the current registered `sel`.
  - `valid` ← OR of the current `gnt`.
  - When `valid` goes low, `dout` keeps its last captured value.
- Reset values:
  - `gnt` = 0, `sel` = 0, `dout` = 0, `valid` = 0.
  - State `IDLE`, `hold_cnt` = 0.
  - `last` = 3, so requester 0 has first priority after reset.

## Timing
- Request to grant latency: 1 cycle. `req` is sampled at edge N and `gnt` is visible after edge N.
- Grant to data latency: 1 cycle. Data selected while `gnt` is high appears on `dout` with `valid` after the next edge. Total request to data latency is 2 cycles.
- Handover between two owners takes zero dead cycles: `gnt` moves directly from one-hot k to one-hot j.
- Simultaneous requests are resolved purely by the pointer order, never by index priority.
- A requester dropping `req` loses its grant at the next edge. Its data may still appear on `dout` for one cycle because of the pipeline stage.
- Reset asserted mid-operation clears every output and state register immediately, without waiting for a clock edge. After deassertion, the first sampled edge behaves as `IDLE`.

## Structure
- Shared package holds:
  - Constant `N_REQ` = 4.
  - Localparams for state encoding (`IDLE` = 0, `GRANT` = 1).
  - Width helper for `hold_cnt`: 4 bits, covering `MAX_HOLD` ≤ 15.
- One combinational sub-module, `rr_pick`:
  - Inputs: `req[3:0]` and `start[1:0]`.
  - Outputs: `any` and `idx[1:0]`, the first set bit at or after `start`, wrapping.
  - The top-level instance uses `start = last+1` for new grants and for switches.
- The 4:1 select on `din` is an indexed part-select inside the top module. No separate mux instance is needed.

## Test plan
- Reset/idle: hold `rst_n` = 0, then release with `req` = 0000. Require `gnt` = 0000, `sel` = 00, `dout` = 0 and `valid` = 0 for 5 cycles.
- Single request: `req` = 0100 with `din` = 4'b0100 (`DATA_W` = 1). Require `gnt` = 0100 and `sel` = 10 after 1 edge, then `dout` = 1 and `valid` = 1 after 2 edges.
- Fairness: hold `req` = 1111 with `MAX_HOLD` = 2. Require grant order 0,0,1,1,2,2,3,3,0 on consecutive cycles.
- Early release handover: owner 1 drops `req[1]` while `req[3]` is high. Require `gnt` to go 0010 → 1000 with no zero cycle between them.
- Lone holder past the limit: `req` = 0001 for 10 cycles with `MAX_HOLD` = 4. Require `gnt` = 0001 throughout and `hold_cnt` cycling 1–4.
- Mid-operation reset: pull `rst_n` low between edges while `gnt` = 0100. Require all outputs to read 0 immediately. After release with `req` = 1100, require the first grant to be 0100, because `last` = 3 so requester 0 is searched first and the first set bit after it is requester 2.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and grant helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 4;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = S_IDLE,
    GRANT = S_GRANT
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational rotating priority pick: first set request at or after start, wrapping.
// Zero latency; no backpressure, purely a function of its inputs.
module rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    any   = |req;
    idx   = start;
    found = 1'b0;
    cand  = start;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 mux select; 1 cycle req->gnt, 1 more cycle gnt->dout/valid.
// No backpressure: a requester keeps the grant at most MAX_HOLD cycles while others wait.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]        sel,
  output logic [DATA_W-1:0]       dout,
  output logic                    valid
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    pick_start;
  logic                grant_new;

  assign pick_start = last_q + 2'd1;

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_new  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) grant_new = 1'b1;
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (pick_any) begin
            grant_new = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          // Search from last+1 reaches the owner itself only when nobody else waits.
          grant_new = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d    = GRANT;
      gnt_d      = idx2onehot(pick_idx);
      sel_d      = pick_idx;
      last_d     = pick_idx;
      hold_cnt_d = HOLD_W'(1);
    end
  end

  always_comb begin
    valid_d = |gnt_q;
    dout_d  = dout_q;
    if (|gnt_q) dout_d = din[sel_q*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench: two arbiter instances (DATA_W=1/MAX_HOLD=4 and DATA_W=4/MAX_HOLD=2) on shared req and reset.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  din_a;
  logic [15:0] din_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [1:0]  sel_a, sel_b;
  logic        dout_a;
  logic [3:0]  dout_b;
  logic        valid_a, valid_b;

  int n_chk;
  int n_fail;

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din_a),
    .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .valid(valid_a)
  );

  mux4_rr_arbiter #(.DATA_W(4), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din_b),
    .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dout;
    logic       valid;
  } vec_t;

  vec_t tbl[13];

  // Reference model: owner index (-1 = none), pointer, hold count, registered outputs.
  int          m_owner[2];
  int          m_last[2];
  int          m_hold[2];
  int          m_sel[2];
  int          m_maxh[2];
  logic [15:0] m_dout[2];
  logic        m_valid[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_hold[i]  = 0;
      m_sel[i]   = 0;
      m_dout[i]  = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_grant(input int i, input int c);
    m_owner[i] = c;
    m_last[i]  = c;
    m_sel[i]   = c;
    m_hold[i]  = 1;
  endtask

  task automatic model_step(input int i, input logic [3:0] r, input logic [15:0] d, input int w);
    int k, c, co;
    k = m_owner[i];
    if (k >= 0) m_dout[i] = (d >> (k * w)) & ((16'd1 << w) - 16'd1);
    m_valid[i] = (k >= 0);
    c  = -1;
    co = -1;
    for (int j = 1; j <= 4; j++)
      if (c < 0 && r[(m_last[i] + j) % 4]) c = (m_last[i] + j) % 4;
    for (int j = 1; j <= 3; j++)
      if (co < 0 && r[(m_last[i] + j) % 4]) co = (m_last[i] + j) % 4;
    if (k < 0) begin
      if (c >= 0) model_grant(i, c);
    end else if (!r[k]) begin
      if (c >= 0) model_grant(i, c);
      else begin
        m_owner[i] = -1;
        m_hold[i]  = 0;
      end
    end else if (m_hold[i] < m_maxh[i]) begin
      m_hold[i]++;
    end else if (co >= 0) begin
      model_grant(i, co);
    end else begin
      m_hold[i] = 1;
    end
  endtask

  function automatic logic [31:0] model_gnt(input int i);
    return (m_owner[i] >= 0) ? (32'd1 << m_owner[i]) : 32'd0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    din_a = '0;
    din_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fair_exp[9];
    n_chk  = 0;
    n_fail = 0;
    m_maxh[0] = 4;
    m_maxh[1] = 2;
    rst_n = 1'b1;
    req   = '0;
    din_a = '0;
    din_b = '0;

    //              req      din      gnt      sel   dout  valid
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[7]  = '{4'b1000, 4'b0101, 4'b1000, 2'd3, 1'b0, 1'b1};
    tbl[8]  = '{4'b1001, 4'b0101, 4'b1000, 2'd3, 1'b0, 1'b1};
    tbl[9]  = '{4'b1001, 4'b1101, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[10] = '{4'b1001, 4'b1101, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[11] = '{4'b1001, 4'b0101, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{4'b0001, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};

    // Reset and idle
    do_reset();
    #1;
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt_a), 32'd0);
      chk("idle_sel", 32'(sel_a), 32'd0);
      chk("idle_dout", 32'(dout_a), 32'd0);
      chk("idle_valid", 32'(valid_a), 32'd0);
    end

    // Directed table: single request, release, handover, hold limit with switch
    do_reset();
    for (int v = 0; v < 13; v++) begin
      req   = tbl[v].req;
      din_a = tbl[v].din;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", v), 32'(gnt_a), 32'(tbl[v].gnt));
      chk($sformatf("tbl%0d_sel", v), 32'(sel_a), 32'(tbl[v].sel));
      chk($sformatf("tbl%0d_dout", v), 32'(dout_a), 32'(tbl[v].dout));
      chk($sformatf("tbl%0d_valid", v), 32'(valid_a), 32'(tbl[v].valid));
    end

    // Fairness with MAX_HOLD=2 under full load
    fair_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("fair%0d_gnt", c), 32'(gnt_b), 32'd1 << fair_exp[c]);
      chk($sformatf("fair%0d_sel", c), 32'(sel_b), 32'(fair_exp[c]));
    end

    // Lone holder past the limit: counter cycles 1..4, grant never drops
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("lone%0d_gnt", c), 32'(gnt_a), 32'd1);
      chk($sformatf("lone%0d_hold", c), 32'(dut_a.hold_cnt_q), 32'((c % 4) + 1));
    end

    // Asynchronous reset mid-grant
    do_reset();
    req   = 4'b0100;
    din_a = 4'b0100;
    @(negedge clk);
    chk("mid_gnt_pre", 32'(gnt_a), 32'b0100);
    @(negedge clk);
    chk("mid_valid_pre", 32'(valid_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_gnt_rst", 32'(gnt_a), 32'd0);
    chk("mid_sel_rst", 32'(sel_a), 32'd0);
    chk("mid_dout_rst", 32'(dout_a), 32'd0);
    chk("mid_valid_rst", 32'(valid_a), 32'd0);
    @(negedge clk);
    req   = 4'b1100;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_first_gnt", 32'(gnt_a), 32'b0100);

    // Randomized traffic against the reference model, both instances
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      din_a = 4'($urandom);
      din_b = 16'($urandom);
      @(posedge clk);
      model_step(0, req, {12'b0, din_a}, 1);
      model_step(1, req, din_b, 4);
      @(negedge clk);
      chk("rnd_a_gnt", 32'(gnt_a), model_gnt(0));
      chk("rnd_a_sel", 32'(sel_a), 32'(m_sel[0]));
      chk("rnd_a_dout", 32'(dout_a), 32'(m_dout[0]));
      chk("rnd_a_valid", 32'(valid_a), 32'(m_valid[0]));
      chk("rnd_b_gnt", 32'(gnt_b), model_gnt(1));
      chk("rnd_b_sel", 32'(sel_b), 32'(m_sel[1]));
      chk("rnd_b_dout", 32'(dout_b), 32'(m_dout[1]));
      chk("rnd_b_valid", 32'(valid_b), 32'(m_valid[1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
